ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Round-robin with a bounded lock, combinational grant, one-cycle read return.
module ram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_wrEn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_wrEn,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] addr_toRAM,
  output logic [DATA_W-1:0] data_toRAM,
  output logic              wrEn,
  input  logic [DATA_W-1:0] data_fromRAM
);

  // Handshake: a master holds req and its command stable until it sees gnt
  // in the same cycle; a granted read returns rvalid/rdata exactly one
  // cycle later, with no backpressure on the return path.

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  // bit 0: master granted most recently; bit 1: that grant carried lock
  // and happened in the previous cycle.
  typedef enum logic [1:0] {
    OWN0  = 2'd0,
    OWN1  = 2'd1,
    LOCK0 = 2'd2,
    LOCK1 = 2'd3
  } arb_state_t;

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             rd_pend, rd_pend_nxt;
  logic             rd_own, rd_own_nxt;

  logic owner, locked;
  logic g0, g1, any_gnt, sel;
  logic sel_lock, sel_wr, other_req;

  assign owner  = state[0];
  assign locked = state[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OWN1;
      lock_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_own   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      rd_pend  <= rd_pend_nxt;
      rd_own   <= rd_own_nxt;
    end
  end

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (m0_req && m1_req) begin
      if (locked && (lock_cnt < MAX_CNT)) begin
        g0 = ~owner;
        g1 = owner;
      end else begin
        g0 = owner;
        g1 = ~owner;
      end
    end else begin
      g0 = m0_req;
      g1 = m1_req;
    end

    any_gnt   = g0 | g1;
    sel       = g1;
    sel_lock  = sel ? m1_lock : m0_lock;
    sel_wr    = sel ? m1_wrEn : m0_wrEn;
    other_req = sel ? m0_req : m1_req;

    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    rd_pend_nxt  = 1'b0;
    rd_own_nxt   = rd_own;

    // The counter holds the number of contended grants in the current run,
    // so a change of owner restarts it at this grant's own contribution.
    if (any_gnt) begin
      state_nxt = arb_state_t'({sel_lock, sel});
      if (sel != owner)
        lock_cnt_nxt = other_req ? CNT_W'(1) : '0;
      else if (other_req)
        lock_cnt_nxt = lock_cnt + CNT_W'(1);
      rd_pend_nxt = ~sel_wr;
      rd_own_nxt  = sel;
    end else begin
      state_nxt    = arb_state_t'({1'b0, owner});
      lock_cnt_nxt = '0;
    end
  end

  always_comb begin
    m0_gnt     = g0 & ~rst;
    m1_gnt     = g1 & ~rst;
    addr_toRAM = '0;
    data_toRAM = '0;
    wrEn       = 1'b0;
    if (m0_gnt) begin
      addr_toRAM = m0_addr;
      data_toRAM = m0_wdata;
      wrEn       = m0_wrEn;
    end else if (m1_gnt) begin
      addr_toRAM = m1_addr;
      data_toRAM = m1_wdata;
      wrEn       = m1_wrEn;
    end
    m0_rvalid = rd_pend & ~rd_own;
    m1_rvalid = rd_pend & rd_own;
    m0_rdata  = m0_rvalid ? data_fromRAM : '0;
    m1_rdata  = m1_rvalid ? data_fromRAM : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table, hand-written lock/reset sequences,
// and randomized traffic checked against a grant-history reference model.
module tb_ram_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int ML = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_lock, m0_wrEn, m1_req, m1_lock, m1_wrEn;
  logic [AW-1:0] m0_addr, m1_addr, addr_toRAM;
  logic [DW-1:0] m0_wdata, m1_wdata, data_toRAM, data_fromRAM;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, wrEn;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr_q = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_wrEn(m0_wrEn), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_wrEn(m1_wrEn), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM), .wrEn(wrEn),
    .data_fromRAM(data_fromRAM)
  );

  // RAM stand-in: contents are a fixed function of the address.
  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    logic [31:0] h;
    if (a == 13'h0010) return 16'hAAAA;
    if (a == 13'h0020) return 16'hBBBB;
    h = 32'(a) * 32'h9E37;
    return h[DW-1:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clk) ram_addr_q <= addr_toRAM;
  assign data_fromRAM = ram_f(ram_addr_q);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input logic eg0, input logic eg1, input logic [AW-1:0] ea,
                           input logic [DW-1:0] ed, input logic ew, input logic erv0,
                           input logic erv1, input logic [DW-1:0] erd0,
                           input logic [DW-1:0] erd1);
    chk("m0_gnt", 32'(m0_gnt), 32'(eg0));
    chk("m1_gnt", 32'(m1_gnt), 32'(eg1));
    chk("addr_toRAM", 32'(addr_toRAM), 32'(ea));
    chk("data_toRAM", 32'(data_toRAM), 32'(ed));
    chk("wrEn", 32'(wrEn), 32'(ew));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(erv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(erv1));
    chk("m0_rdata", 32'(m0_rdata), 32'(erd0));
    chk("m1_rdata", 32'(m1_rdata), 32'(erd1));
  endtask

  task automatic set_m0(input logic r, input logic l, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_req = r; m0_lock = l; m0_wrEn = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic l, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_req = r; m1_lock = l; m1_wrEn = w; m1_addr = a; m1_wdata = d;
  endtask

  // Reference model: a log of every cycle's grant, from which ownership,
  // lock state and the contended run length are recomputed on demand.
  int          gh[$];
  bit          oh[$];
  bit          lh[$];
  bit          rh[$];
  logic [AW-1:0] ah[$];

  task automatic model_clear();
    gh.delete(); oh.delete(); lh.delete(); rh.delete(); ah.delete();
  endtask

  function automatic int model_grant();
    int owner = 1;
    int prev  = -1;
    int run   = 0;
    bit lock_on;
    for (int i = gh.size() - 1; i >= 0; i--)
      if (gh[i] != -1) begin owner = gh[i]; break; end
    if (gh.size() > 0) prev = gh[gh.size()-1];
    lock_on = (prev != -1) && lh[lh.size()-1];
    for (int i = gh.size() - 1; i >= 0; i--) begin
      if (gh[i] != prev) break;
      if (oh[i]) run++;
    end
    if (m0_req && m1_req) begin
      if (lock_on && run < ML) return prev;
      return 1 - owner;
    end
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  task automatic model_check(input int g);
    int prev = (gh.size() > 0) ? gh[gh.size()-1] : -1;
    bit rv0 = (prev == 0) && rh[rh.size()-1];
    bit rv1 = (prev == 1) && rh[rh.size()-1];
    logic [DW-1:0] rd = (rv0 || rv1) ? ram_f(ah[ah.size()-1]) : '0;
    check_out(g == 0, g == 1,
              (g == 0) ? m0_addr : (g == 1) ? m1_addr : '0,
              (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : '0,
              (g == 0) ? m0_wrEn : (g == 1) ? m1_wrEn : 1'b0,
              rv0, rv1, rv0 ? rd : '0, rv1 ? rd : '0);
  endtask

  task automatic model_commit(input int g);
    gh.push_back(g);
    oh.push_back((g == 0) ? m1_req : (g == 1) ? m0_req : 1'b0);
    lh.push_back((g == 0) ? m0_lock : (g == 1) ? m1_lock : 1'b0);
    rh.push_back((g == 0) ? !m0_wrEn : (g == 1) ? !m1_wrEn : 1'b0);
    ah.push_back((g == 0) ? m0_addr : (g == 1) ? m1_addr : '0);
  endtask

  task automatic apply_reset();
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    rst = 1'b1;
    #1;
    check_out(0, 0, '0, '0, 0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic r0, l0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, l1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic eg0, eg1; logic [AW-1:0] ea; logic [DW-1:0] ed; logic ew;
    logic erv0, erv1; logic [DW-1:0] erd0, erd1;
  } vec_t;

  vec_t vt[7];

  initial begin
    int g, n;
    vt[0] = '{1, 0, 0, 13'h0010, 16'h1111, 1, 0, 0, 13'h0020, 16'h2222,
              1, 0, 13'h0010, 16'h1111, 0, 0, 0, 16'h0, 16'h0};
    vt[1] = '{0, 0, 0, 13'h0000, 16'h0000, 1, 0, 0, 13'h0020, 16'h2222,
              0, 1, 13'h0020, 16'h2222, 0, 1, 0, 16'hAAAA, 16'h0};
    vt[2] = '{0, 0, 0, 13'h0000, 16'h0000, 0, 0, 0, 13'h0000, 16'h0000,
              0, 0, 13'h0000, 16'h0000, 0, 0, 1, 16'h0, 16'hBBBB};
    vt[3] = '{0, 0, 0, 13'h0000, 16'h0000, 1, 0, 1, 13'h1FFF, 16'h1234,
              0, 1, 13'h1FFF, 16'h1234, 1, 0, 0, 16'h0, 16'h0};
    vt[4] = '{0, 1, 0, 13'h0000, 16'h0000, 0, 1, 0, 13'h0000, 16'h0000,
              0, 0, 13'h0000, 16'h0000, 0, 0, 0, 16'h0, 16'h0};
    vt[5] = '{1, 0, 0, 13'h0003, 16'h0033, 1, 0, 0, 13'h0004, 16'h0044,
              1, 0, 13'h0003, 16'h0033, 0, 0, 0, 16'h0, 16'h0};
    vt[6] = '{0, 0, 0, 13'h0000, 16'h0000, 1, 0, 0, 13'h0004, 16'h0044,
              0, 1, 13'h0004, 16'h0044, 0, 1, 0, ram_f(13'h0003), 16'h0};

    apply_reset();
    foreach (vt[i]) begin
      set_m0(vt[i].r0, vt[i].l0, vt[i].w0, vt[i].a0, vt[i].d0);
      set_m1(vt[i].r1, vt[i].l1, vt[i].w1, vt[i].a1, vt[i].d1);
      @(negedge clk);
      check_out(vt[i].eg0, vt[i].eg1, vt[i].ea, vt[i].ed, vt[i].ew,
                vt[i].erv0, vt[i].erv1, vt[i].erd0, vt[i].erd1);
      @(posedge clk); #1;
    end

    // Reset arriving in the same cycle as a granted read.
    apply_reset();
    set_m0(1, 0, 0, 13'h0005, 16'h0);
    set_m1(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rstread_gnt", 32'(m0_gnt), 32'd1);
    chk("rstread_addr", 32'(addr_toRAM), 32'h5);
    #2 rst = 1'b1;
    #1 check_out(0, 0, '0, '0, 0, 0, 0, '0, '0);
    set_m0(0, 0, 0, '0, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstread_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rstread_rdata", 32'(m0_rdata), 32'd0);
    set_m0(1, 0, 1, 13'h0007, 16'h0009);
    #1 chk("first_gnt_after_rst", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;

    // Lock bound under continuous contention.
    apply_reset();
    set_m0(1, 1, 0, 13'h0100, 16'h0);
    set_m1(1, 0, 0, 13'h0200, 16'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("lockbound_g0", 32'(m0_gnt), 32'(i != 8));
      chk("lockbound_g1", 32'(m1_gnt), 32'(i == 8));
      @(posedge clk); #1;
    end

    // Uncontended lock does not consume the bound.
    apply_reset();
    set_m0(1, 1, 1, 13'h0300, 16'h0055);
    set_m1(0, 0, 0, '0, '0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_gnt) n++;
      @(posedge clk); #1;
    end
    chk("nolock_contention_cnt", 32'(n), 32'd20);
    set_m1(1, 0, 1, 13'h0400, 16'h0066);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("latecontend_g0", 32'(m0_gnt), 32'(i < 8));
      chk("latecontend_g1", 32'(m1_gnt), 32'(i == 8));
      @(posedge clk); #1;
    end

    // Randomized traffic; commands stay stable until granted.
    apply_reset();
    g = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!m0_req || g == 0)
        set_m0($urandom_range(0, 3) != 0, 0, $urandom_range(0, 1) == 1,
               AW'($urandom), DW'($urandom));
      if (!m1_req || g == 1)
        set_m1($urandom_range(0, 3) != 0, 0, $urandom_range(0, 1) == 1,
               AW'($urandom), DW'($urandom));
      m0_lock = $urandom_range(0, 2) != 0;
      m1_lock = $urandom_range(0, 2) != 0;
      @(negedge clk);
      g = model_grant();
      model_check(g);
      model_commit(g);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
